// File: rtl/otp_display_scheduler.sv
// Time-multiplexed 4-digit display driver that shares the display between a user
// OTP and an LFSR OTP, with blanking dead-time and frame-based source arbitration.
module otp_display_scheduler #(
    parameter int DIGIT_CYC      = 1000,
    parameter int BLANK_CYC      = 16,
    parameter int FRAMES_PER_SRC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] user_otp,
    input  logic [15:0] lfsr_otp,
    input  logic        user_req,
    input  logic        lfsr_req,
    input  logic        freeze,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        src,
    output logic        frame_done
);
    localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int FRM_W   = $clog2(FRAMES_PER_SRC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [FRM_W-1:0] r_frames;
    logic [15:0]      r_snap;
    logic             r_src;
    logic [3:0]       r_an;
    logic [3:0]       r_bcd;
    logic             r_frame_done;

    logic             w_any_req;
    logic             w_cur_req;
    logic             w_src_nxt;
    logic [FRM_W-1:0] w_frames_inc;
    logic [FRM_W-1:0] w_frames_nxt;
    logic [15:0]      w_snap_nxt;

    // Arbitration result, consumed only on IDLE exit and at frame boundaries.
    // The frame count saturates so a long freeze cannot wrap it.
    always_comb begin
        w_any_req    = user_req | lfsr_req;
        w_cur_req    = r_src ? lfsr_req : user_req;
        w_frames_inc = (r_frames >= FRM_W'(FRAMES_PER_SRC)) ? r_frames : r_frames + 1'b1;
        w_src_nxt    = r_src;
        w_frames_nxt = w_frames_inc;
        if (r_state == S_IDLE) begin
            w_src_nxt    = ~user_req & lfsr_req;
            w_frames_nxt = '0;
        end else if (freeze && w_cur_req) begin
            w_src_nxt = r_src;
        end else if (user_req && lfsr_req) begin
            if (w_frames_inc >= FRM_W'(FRAMES_PER_SRC)) begin
                w_src_nxt = ~r_src;
            end
        end else if (w_any_req) begin
            w_src_nxt = lfsr_req;
        end else begin
            w_frames_nxt = '0;
        end
        if (w_src_nxt != r_src) begin
            w_frames_nxt = '0;
        end
        w_snap_nxt = w_src_nxt ? lfsr_otp : user_otp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_frames     <= '0;
            r_snap       <= 16'h0000;
            r_src        <= 1'b0;
            r_an         <= 4'hF;
            r_bcd        <= 4'h0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_an  <= 4'hF;
                    r_bcd <= 4'h0;
                    if (w_any_req) begin
                        r_src    <= w_src_nxt;
                        r_frames <= w_frames_nxt;
                        r_snap   <= w_snap_nxt;
                        r_idx    <= 2'd0;
                        r_cnt    <= '0;
                        r_state  <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_an    <= ~(4'b0001 << r_idx);
                        r_bcd   <= r_snap[{r_idx, 2'b00} +: 4];
                        r_state <= S_DRIVE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == CNT_W'(DIGIT_CYC - 1)) begin
                        r_cnt <= '0;
                        r_an  <= 4'hF;
                        r_bcd <= 4'h0;
                        if (r_idx != 2'd3) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_BLANK;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_idx        <= 2'd0;
                            if (w_any_req) begin
                                r_src    <= w_src_nxt;
                                r_frames <= w_frames_nxt;
                                r_snap   <= w_snap_nxt;
                                r_state  <= S_BLANK;
                            end else begin
                                r_frames <= '0;
                                r_state  <= S_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_an    <= 4'hF;
                    r_bcd   <= 4'h0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd        = r_bcd;
    assign an         = r_an;
    assign src        = r_src;
    assign frame_done = r_frame_done;
endmodule
